uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer and mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] obyte,
  output logic       obyte_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  logic [1:0]    r_sync;
  logic          w_rxs;
  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [7:0]    r_obyte, w_obyte_nxt;
  logic          r_ready, w_ready_nxt;
  logic          r_ferr, w_ferr_nxt;
  logic          r_busy;
`ifdef UART_RX_PARITY_EN
  logic          r_par, w_par_nxt;
  logic          r_perr, w_perr_nxt;

  function automatic logic f_even_par(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  assign w_rxs = r_sync[1];

  // Input synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  // State, datapath and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_obyte <= 8'h00;
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_obyte <= w_obyte_nxt;
      r_ready <= w_ready_nxt;
      r_ferr  <= w_ferr_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_nxt;
      r_perr  <= w_perr_nxt;
`endif
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer + TW'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_obyte_nxt = r_obyte;
    w_ready_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
    w_perr_nxt  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (!w_rxs) begin
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (r_timer == T_HALF) begin
          w_timer_nxt = '0;
          w_idx_nxt   = 3'd0;
          // A start bit that is high again at mid-bit was only a glitch.
          if (!w_rxs) begin
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        if (r_timer == T_FULL) begin
          w_timer_nxt = '0;
          w_shift_nxt = {w_rxs, r_shift[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_timer == T_FULL) begin
          w_timer_nxt = '0;
          w_par_nxt   = w_rxs;
          w_state_nxt = S_STOP;
        end else begin
          w_state_nxt = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (r_timer == T_FULL) begin
          w_timer_nxt = '0;
          if (w_rxs) begin
            w_state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (r_par != f_even_par(r_shift)) begin
              w_perr_nxt = 1'b1;
            end else begin
              w_obyte_nxt = r_shift;
              w_ready_nxt = 1'b1;
            end
`else
            w_obyte_nxt = r_shift;
            w_ready_nxt = 1'b1;
`endif
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      S_WAIT_HIGH: begin
        w_timer_nxt = '0;
        if (w_rxs) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_HIGH;
        end
      end
      default: begin
        w_timer_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign obyte       = r_obyte;
  assign obyte_ready = r_ready;
  assign frame_err   = r_ferr;
  assign busy        = r_busy;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = r_perr;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit; stimulus pushes expected
// strobes, a negedge monitor pops and compares them as they appear.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam longint LAT = 2 + CPB / 2 + 10 * CPB;
`else
  localparam longint LAT = 2 + CPB / 2 + 9 * CPB;
`endif
  localparam int K_READY = 0;
  localparam int K_FERR  = 1;
  localparam int K_PERR  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] obyte;
  logic       obyte_ready;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  typedef struct {
    int         kind;
    logic [7:0] b;
    longint     t;
  } exp_t;

  exp_t   q[$];
  longint cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .obyte      (obyte),
    .obyte_ready(obyte_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] b);
    exp_t e;
    e.kind = kind;
    e.b    = b;
    e.t    = cyc + LAT;
    q.push_back(e);
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_data(input logic [7:0] b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb);
    send_data(b);
`ifdef UART_RX_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stopb);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_bad_par(input logic [7:0] b);
    send_data(b);
    send_bit(~^b);
    send_bit(1'b1);
  endtask
`endif

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_obyte"}, obyte, 8'h00);
    check({tag, "_ready"}, {7'd0, obyte_ready}, 8'h00);
    check({tag, "_ferr"},  {7'd0, frame_err},   8'h00);
    check({tag, "_perr"},  {7'd0, parity_err},  8'h00);
    check({tag, "_busy"},  {7'd0, busy},        8'h00);
  endtask

  // Scoreboard monitor: every strobe must match the head of the queue.
  always @(negedge clk) begin
    if (obyte_ready || frame_err || parity_err) begin
      exp_t   e;
      int     kind;
      longint d;
      check("strobe_onehot",
            8'(int'(obyte_ready) + int'(frame_err) + int'(parity_err)), 8'd1);
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: got rdy=%b ferr=%b perr=%b obyte=%h, expected none (cycle %0d)",
                 obyte_ready, frame_err, parity_err, obyte, cyc);
      end else begin
        e    = q.pop_front();
        kind = obyte_ready ? K_READY : (frame_err ? K_FERR : K_PERR);
        check("strobe_kind", 8'(kind), 8'(e.kind));
        check("obyte", obyte, e.b);
        d = cyc - e.t;
        n_vec++;
        if (d > 1 || d < -1) begin
          n_err++;
          $display("FAIL latency: strobe at cycle %0d, expected %0d +-1", cyc, e.t);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] b81;
    longint     t0;
    b81 = 8'h81;

    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    idle(5);

    expect_ev(K_READY, 8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(20);

    expect_ev(K_READY, 8'h00);
    send_frame(8'h00, 1'b1);
    expect_ev(K_READY, 8'hFF);
    send_frame(8'hFF, 1'b1);
    idle(20);

    t0 = cyc;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_busy_high", {7'd0, busy}, 8'h01);
    rx = 1'b1;
    while (cyc < t0 + 12) @(negedge clk);
    check("glitch_busy_low", {7'd0, busy}, 8'h00);
    idle(20);

    expect_ev(K_FERR, 8'hFF);
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (24) @(negedge clk);
    idle(32);
    expect_ev(K_READY, 8'h55);
    send_frame(8'h55, 1'b1);
    idle(20);

    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b81[i]);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("midreset");
    rst_n = 1'b1;
    idle(40);
    check("post_reset_busy", {7'd0, busy}, 8'h00);
    expect_ev(K_READY, 8'h42);
    send_frame(8'h42, 1'b1);
    idle(20);

`ifdef UART_RX_PARITY_EN
    expect_ev(K_READY, 8'h07);
    send_frame(8'h07, 1'b1);
    idle(20);
    expect_ev(K_PERR, 8'h07);
    send_bad_par(8'h07);
    idle(20);
`endif

    t0 = cyc;
    while (q.size() != 0 && cyc < t0 + 500) @(negedge clk);
    check("queue_drained", 8'(q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
